// File: rtl/game_pkg.sv
// Shared types and default tuning constants for the dinosaur-runner sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } game_state_e;

    localparam int SPEED_W        = 3;
    localparam int SCORE_W_DEF    = 14;
    localparam int SCORE_DIV_DEF  = 6;
    localparam int SPEED_STEP_DEF = 100;
    localparam int MAX_LVL_DEF    = 7;
    localparam int GRACE_FRM_DEF  = 30;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser for an async level, followed by a registered single-cycle
// edge pulse (rising by default, falling when FALL_EDGE is set).
module btn_sync_edge #(
    parameter bit FALL_EDGE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic edge_o
);

    logic [2:0] sh_q;
    logic       edge_q;
    logic       edge_d;

    assign edge_d = FALL_EDGE ? (~sh_q[1] &  sh_q[2])
                              : ( sh_q[1] & ~sh_q[2]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q   <= '0;
            edge_q <= 1'b0;
        end else begin
            sh_q   <= {sh_q[1:0], d_i};
            edge_q <= edge_d;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/game_ctrl.sv
// Dinosaur-runner game sequencer: IDLE/RUN/PAUSE/OVER FSM, per-frame jump latch,
// collision latch with restart grace, score/speed counters. GAME_HISCORE_EN adds hiscore.
module game_ctrl
    import game_pkg::*;
#(
    parameter int SCORE_W    = SCORE_W_DEF,
    parameter int SCORE_DIV  = SCORE_DIV_DEF,
    parameter int SPEED_STEP = SPEED_STEP_DEF,
    parameter int MAX_LVL    = MAX_LVL_DEF,
    parameter int GRACE_FRM  = GRACE_FRM_DEF
) (
    input  logic               clk,
    input  logic               RESET_n,
    input  logic               fresh,
    input  logic               btn_start,
    input  logic               btn_pause,
    input  logic               btn_jump,
    input  logic               dino_px,
    input  logic               obst_px,
    output logic               game_status,
    output logic               restart,
    output logic               jump_req,
    output logic               game_over,
    output logic               frame_tick,
    output logic [SCORE_W-1:0] score,
    output logic [SPEED_W-1:0] speed_lvl
`ifdef GAME_HISCORE_EN
    ,
    output logic [SCORE_W-1:0] hiscore
`endif
);

    localparam int DIV_W  = (SCORE_DIV  > 1) ? $clog2(SCORE_DIV)  : 1;
    localparam int STEP_W = (SPEED_STEP > 1) ? $clog2(SPEED_STEP) : 1;
    localparam int GR_W   = (GRACE_FRM  > 0) ? $clog2(GRACE_FRM + 1) : 1;

    // Bit order: start, pause, jump, fresh (fresh uses the falling edge).
    logic [3:0] raw, edg;
    assign raw = {fresh, btn_jump, btn_pause, btn_start};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        btn_sync_edge #(.FALL_EDGE(i == 3)) u_sync (
            .clk_i  (clk),
            .rst_ni (RESET_n),
            .d_i    (raw[i]),
            .edge_o (edg[i])
        );
    end

    logic start_e, pause_e, jump_e, tick;
    assign start_e = edg[0];
    assign pause_e = edg[1];
    assign jump_e  = edg[2];
    assign tick    = edg[3];

    game_state_e         state_q, state_d;
    logic                rst_game;
    logic                restart_q;
    logic                hit_q, jump_q, seen_q;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [SPEED_W-1:0]  lvl_q, lvl_d;
    logic [GR_W-1:0]     grace_q, grace_d;
    logic                run_tick, ovl;

    assign run_tick = tick & (state_q == ST_RUN);
    assign ovl      = dino_px & obst_px & (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        rst_game = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: if (start_e) begin
                state_d  = ST_RUN;
                rst_game = 1'b1;
            end
            ST_RUN: begin
                if (tick && hit_q && grace_q == '0) state_d = ST_OVER;
                else if (pause_e)                   state_d = ST_PAUSE;
            end
            ST_PAUSE: if (pause_e || start_e) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Counters advance only on RUN frame ticks, including the tick that ends the game.
    always_comb begin
        div_d   = div_q;
        step_d  = step_q;
        score_d = score_q;
        lvl_d   = lvl_q;
        grace_d = grace_q;
        if (rst_game) begin
            div_d   = '0;
            step_d  = '0;
            score_d = '0;
            lvl_d   = '0;
            grace_d = GR_W'(GRACE_FRM);
        end else if (run_tick) begin
            if (grace_q != '0) grace_d = grace_q - 1'b1;
            if (div_q == DIV_W'(SCORE_DIV - 1)) begin
                div_d = '0;
                if (score_q != '1) score_d = score_q + 1'b1;
                if (step_q == STEP_W'(SPEED_STEP - 1)) begin
                    step_d = '0;
                    if (lvl_q != SPEED_W'(MAX_LVL)) lvl_d = lvl_q + 1'b1;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= ST_IDLE;
            restart_q <= 1'b0;
            div_q     <= '0;
            step_q    <= '0;
            score_q   <= '0;
            lvl_q     <= '0;
            grace_q   <= '0;
        end else begin
            state_q   <= state_d;
            restart_q <= rst_game;
            div_q     <= div_d;
            step_q    <= step_d;
            score_q   <= score_d;
            lvl_q     <= lvl_d;
            grace_q   <= grace_d;
        end
    end

    // An overlap landing on the tick cycle belongs to the frame that is starting.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n)      hit_q <= 1'b0;
        else if (rst_game) hit_q <= 1'b0;
        else if (tick)     hit_q <= ovl;
        else if (ovl)      hit_q <= 1'b1;
    end

    // seen_q marks that the request has been presented at one frame boundary.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) begin
            jump_q <= 1'b0;
            seen_q <= 1'b0;
        end else if (rst_game) begin
            jump_q <= 1'b0;
            seen_q <= 1'b0;
        end else if (jump_e && state_q == ST_RUN) begin
            jump_q <= 1'b1;
            seen_q <= 1'b0;
        end else if (run_tick && jump_q) begin
            if (seen_q) begin
                jump_q <= 1'b0;
                seen_q <= 1'b0;
            end else begin
                seen_q <= 1'b1;
            end
        end
    end

`ifdef GAME_HISCORE_EN
    logic [SCORE_W-1:0] hiscore_q;
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n)
            hiscore_q <= '0;
        else if (state_q == ST_RUN && state_d == ST_OVER && score_d > hiscore_q)
            hiscore_q <= score_d;
    end
    assign hiscore = hiscore_q;
`endif

    assign game_status = (state_q == ST_RUN);
    assign game_over   = (state_q == ST_OVER);
    assign restart     = restart_q;
    assign jump_req    = jump_q;
    assign frame_tick  = tick;
    assign score       = score_q;
    assign speed_lvl   = lvl_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: frame-level reference model, default and fast-scoring instances.
module tb_game_ctrl;
    localparam int G = 30, DIV = 6, STEP = 100;
    localparam int FW = 4, FDIV = 1, FSTEP = 2;

    logic clk = 1'b0, rst_n = 1'b0, fresh = 1'b0;
    logic bs = 1'b0, bp = 1'b0, bj = 1'b0, dino = 1'b0, obst = 1'b0;
    logic gs, rs, jr, go, ft, f_gs, f_rs, f_jr, f_go, f_ft;
    logic [13:0] sc;
    logic [2:0]  lv, f_lv;
    logic [FW-1:0] f_sc;
`ifdef GAME_HISCORE_EN
    logic [13:0] hs;
    logic [FW-1:0] f_hs;
`endif

    game_ctrl dut (
        .clk(clk), .RESET_n(rst_n), .fresh(fresh), .btn_start(bs), .btn_pause(bp),
        .btn_jump(bj), .dino_px(dino), .obst_px(obst), .game_status(gs), .restart(rs),
        .jump_req(jr), .game_over(go), .frame_tick(ft), .score(sc), .speed_lvl(lv)
`ifdef GAME_HISCORE_EN
        , .hiscore(hs)
`endif
    );

    game_ctrl #(.SCORE_W(FW), .SCORE_DIV(FDIV), .SPEED_STEP(FSTEP)) dut_f (
        .clk(clk), .RESET_n(rst_n), .fresh(fresh), .btn_start(bs), .btn_pause(bp),
        .btn_jump(bj), .dino_px(dino), .obst_px(obst), .game_status(f_gs), .restart(f_rs),
        .jump_req(f_jr), .game_over(f_go), .frame_tick(f_ft), .score(f_sc), .speed_lvl(f_lv)
`ifdef GAME_HISCORE_EN
        , .hiscore(f_hs)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;
    int rst_cnt = 0, tick_cnt = 0;
    int e_rst = 0, e_tick = 0;

    always @(negedge clk) begin
        if (rs) rst_cnt <= rst_cnt + 1;
        if (ft) tick_cnt <= tick_cnt + 1;
    end

    // Model state: 0 idle, 1 run, 2 pause, 3 over; m_frames = RUN frames since restart.
    int m_state = 0, m_frames = 0, m_hi = 0, m_fhi = 0;
    bit m_hit = 0, m_jump = 0, m_seen = 0;

    function automatic int exp_sc(int div, int w);
        int s = m_frames / div;
        int mx = (1 << w) - 1;
        return (s > mx) ? mx : s;
    endfunction

    function automatic int exp_lv(int div, int step);
        int l = m_frames / div / step;
        return (l > 7) ? 7 : l;
    endfunction

    task automatic model_reset();
        m_state = 0; m_frames = 0; m_hi = 0; m_fhi = 0;
        m_hit = 0; m_jump = 0; m_seen = 0;
    endtask

    task automatic model_restart();
        m_state = 1; m_frames = 0; m_hit = 0; m_jump = 0; m_seen = 0;
        e_rst++;
    endtask

    task automatic press(input bit s, input bit p);
        @(posedge clk); #1; bs = s; bp = p;
        repeat (4) @(posedge clk); #1; bs = 1'b0; bp = 1'b0;
        repeat (8) @(posedge clk); #1;
        case (m_state)
            0: if (s) model_restart();
            1: if (p) m_state = 2;
            2: if (s || p) m_state = 1;
            3: if (s) model_restart();
            default: ;
        endcase
    endtask

    task automatic frame(input logic [1:0] px, input bit jmp);
        int hi, lo;
        bit die;
        hi = $urandom_range(8, 14);
        lo = $urandom_range(8, 14);
        @(posedge clk); #1; fresh = 1'b1;
        repeat (2) @(posedge clk); #1;
        if (px != 2'b00) begin
            dino = px[1]; obst = px[0];
            @(posedge clk); #1; dino = 1'b0; obst = 1'b0;
        end
        if (jmp) begin
            bj = 1'b1; repeat (2) @(posedge clk); #1; bj = 1'b0;
        end
        repeat (hi) @(posedge clk); #1; fresh = 1'b0;
        repeat (lo) @(posedge clk); #1;
        e_tick++;
        if (m_state == 1) begin
            if (px == 2'b11) m_hit = 1;
            if (jmp) begin m_jump = 1; m_seen = 0; end
            die = m_hit && (m_frames >= G);
            m_frames++;
            if (m_jump) begin
                if (m_seen) begin m_jump = 0; m_seen = 0; end
                else m_seen = 1;
            end
            if (die) begin
                m_state = 3;
                if (exp_sc(DIV, 14) > m_hi) m_hi = exp_sc(DIV, 14);
                if (exp_sc(FDIV, FW) > m_fhi) m_fhi = exp_sc(FDIV, FW);
            end
        end
        m_hit = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (gs !== 1'b0) begin n_err++; $display("FAIL reset_status: got %b want 0", gs); end
        n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL reset_restart: got %b want 0", rs); end
        n_cmp++; if (jr !== 1'b0) begin n_err++; $display("FAIL reset_jump: got %b want 0", jr); end
        n_cmp++; if (go !== 1'b0) begin n_err++; $display("FAIL reset_over: got %b want 0", go); end
        n_cmp++; if (ft !== 1'b0) begin n_err++; $display("FAIL reset_tick: got %b want 0", ft); end
        n_cmp++; if (sc !== 14'd0) begin n_err++; $display("FAIL reset_score: got %0d want 0", sc); end
        n_cmp++; if (lv !== 3'd0) begin n_err++; $display("FAIL reset_lvl: got %0d want 0", lv); end
        n_cmp++; if ({f_rs, f_ft, f_gs} !== 3'b000) begin n_err++; $display("FAIL reset_fast: got %b want 000", {f_rs, f_ft, f_gs}); end
`ifdef GAME_HISCORE_EN
        n_cmp++; if (hs !== 14'd0) begin n_err++; $display("FAIL reset_hiscore: got %0d want 0", hs); end
`endif
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_idle_frames();
        repeat (2) frame(2'b11, 1'b1);
        n_cmp++; if (tick_cnt !== e_tick) begin n_err++; $display("FAIL idle_ticks: got %0d want %0d", tick_cnt, e_tick); end
        n_cmp++; if (gs !== 1'b0) begin n_err++; $display("FAIL idle_status: got %b want 0", gs); end
        n_cmp++; if (jr !== 1'b0) begin n_err++; $display("FAIL idle_jump: got %b want 0", jr); end
        n_cmp++; if (sc !== 14'd0) begin n_err++; $display("FAIL idle_score: got %0d want 0", sc); end
    endtask

    task automatic test_start();
        press(1'b1, 1'b0);
        n_cmp++; if (rst_cnt !== e_rst) begin n_err++; $display("FAIL start_restart: got %0d pulses want %0d", rst_cnt, e_rst); end
        n_cmp++; if (gs !== 1'b1) begin n_err++; $display("FAIL start_status: got %b want 1", gs); end
        n_cmp++; if (sc !== 14'd0 || lv !== 3'd0) begin n_err++; $display("FAIL start_counters: got %0d/%0d want 0/0", sc, lv); end
    endtask

    task automatic test_score();
        repeat (60) frame(2'b00, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL score60: got %0d want %0d", sc, exp_sc(DIV, 14)); end
        n_cmp++; if (lv !== 3'(exp_lv(DIV, STEP))) begin n_err++; $display("FAIL lvl60: got %0d want %0d", lv, exp_lv(DIV, STEP)); end
        n_cmp++; if (f_sc !== FW'(exp_sc(FDIV, FW))) begin n_err++; $display("FAIL fast_score_sat: got %0d want %0d", f_sc, exp_sc(FDIV, FW)); end
        n_cmp++; if (tick_cnt !== e_tick) begin n_err++; $display("FAIL score_ticks: got %0d want %0d", tick_cnt, e_tick); end
    endtask

    task automatic test_pause();
        press(1'b0, 1'b1);
        n_cmp++; if (gs !== 1'b0 || go !== 1'b0) begin n_err++; $display("FAIL pause_status: got %b%b want 00", gs, go); end
        repeat (19) frame(2'b00, 1'b0);
        frame(2'b11, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL pause_frozen: got %0d want %0d", sc, exp_sc(DIV, 14)); end
        n_cmp++; if (go !== 1'b0) begin n_err++; $display("FAIL pause_hit_ignored: got %b want 0", go); end
        press(1'b0, 1'b1);
        repeat (6) frame(2'b00, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL resume_score: got %0d want %0d", sc, exp_sc(DIV, 14)); end
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        n_cmp++; if (rst_cnt !== e_rst || gs !== 1'b1) begin n_err++; $display("FAIL resume_start: got %0d pulses st %b want %0d st 1", rst_cnt, gs, e_rst); end
        repeat (6) frame(2'b00, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL resume2_score: got %0d want %0d", sc, exp_sc(DIV, 14)); end
    endtask

    task automatic test_collision();
        frame(2'b10, 1'b0);
        n_cmp++; if (gs !== 1'b1) begin n_err++; $display("FAIL near_miss: got %b want 1", gs); end
        frame(2'b11, 1'b0);
        n_cmp++; if (go !== 1'(m_state == 3)) begin n_err++; $display("FAIL hit_over: got %b want %b", go, m_state == 3); end
        repeat (3) frame(2'b00, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL over_frozen: got %0d want %0d", sc, exp_sc(DIV, 14)); end
        press(1'b1, 1'b0);
        n_cmp++; if (rst_cnt !== e_rst || sc !== 14'd0) begin n_err++; $display("FAIL over_restart: got %0d pulses sc %0d want %0d sc 0", rst_cnt, sc, e_rst); end
        for (int i = 1; i <= 40; i++) begin
            frame((i == 10 || i == 30 || i == 40) ? 2'b11 : 2'b00, 1'b0);
            if (i == 10 || i == 30 || i == 40) begin
                n_cmp++; if (go !== 1'(m_state == 3) || gs !== 1'(m_state == 1)) begin
                    n_err++; $display("FAIL grace_f%0d: got run %b over %b want run %b over %b", i, gs, go, m_state == 1, m_state == 3);
                end
            end
        end
        repeat (2) frame(2'b00, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL grace_score: got %0d want %0d", sc, exp_sc(DIV, 14)); end
    endtask

    task automatic test_jump();
        press(1'b1, 1'b0);
        frame(2'b00, 1'b1);
        n_cmp++; if (jr !== 1'b1) begin n_err++; $display("FAIL jump_held: got %b want 1", jr); end
        frame(2'b00, 1'b0);
        n_cmp++; if (jr !== 1'b0) begin n_err++; $display("FAIL jump_clear: got %b want 0", jr); end
        press(1'b0, 1'b1);
        frame(2'b00, 1'b1);
        n_cmp++; if (jr !== 1'b0) begin n_err++; $display("FAIL jump_pause_drop: got %b want 0", jr); end
        press(1'b0, 1'b1);
    endtask

    task automatic test_speed();
        for (int i = 0; i < 20; i++) begin
            frame(2'b00, 1'b0);
            n_cmp++; if (f_lv !== 3'(exp_lv(FDIV, FSTEP))) begin n_err++; $display("FAIL speed_f%0d: got %0d want %0d", i, f_lv, exp_lv(FDIV, FSTEP)); end
        end
    endtask

    task automatic test_both();
        press(1'b1, 1'b1);
        n_cmp++; if (gs !== 1'b0 || rst_cnt !== e_rst) begin n_err++; $display("FAIL both_pause: got st %b pulses %0d want st 0 pulses %0d", gs, rst_cnt, e_rst); end
        press(1'b0, 1'b1);
        n_cmp++; if (gs !== 1'b1) begin n_err++; $display("FAIL both_resume: got %b want 1", gs); end
    endtask

    task automatic test_random();
        logic [1:0] px;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                px = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
                frame(px, $urandom_range(0, 3) == 0);
            end else begin
                press(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            n_cmp++; if ({gs, go} !== {1'(m_state == 1), 1'(m_state == 3)}) begin n_err++; $display("FAIL rnd%0d_state: got %b%b want st %0d", i, gs, go, m_state); end
            n_cmp++; if ({f_gs, f_go} !== {gs, go}) begin n_err++; $display("FAIL rnd%0d_fast_state: got %b%b want %b%b", i, f_gs, f_go, gs, go); end
            n_cmp++; if (sc !== 14'(exp_sc(DIV, 14))) begin n_err++; $display("FAIL rnd%0d_score: got %0d want %0d", i, sc, exp_sc(DIV, 14)); end
            n_cmp++; if (lv !== 3'(exp_lv(DIV, STEP))) begin n_err++; $display("FAIL rnd%0d_lvl: got %0d want %0d", i, lv, exp_lv(DIV, STEP)); end
            n_cmp++; if (f_sc !== FW'(exp_sc(FDIV, FW)) || f_lv !== 3'(exp_lv(FDIV, FSTEP))) begin
                n_err++; $display("FAIL rnd%0d_fast: got %0d/%0d want %0d/%0d", i, f_sc, f_lv, exp_sc(FDIV, FW), exp_lv(FDIV, FSTEP));
            end
            n_cmp++; if (jr !== 1'(m_jump) || f_jr !== 1'(m_jump)) begin n_err++; $display("FAIL rnd%0d_jump: got %b%b want %b", i, jr, f_jr, m_jump); end
            n_cmp++; if (rst_cnt !== e_rst || tick_cnt !== e_tick) begin
                n_err++; $display("FAIL rnd%0d_pulses: got %0d/%0d want %0d/%0d", i, rst_cnt, tick_cnt, e_rst, e_tick);
            end
        end
    endtask

    task automatic test_reset_midframe();
        if (m_state == 2) press(1'b0, 1'b1);
        else if (m_state != 1) press(1'b1, 1'b0);
        repeat (3) frame(2'b00, 1'b1);
        @(posedge clk); #1; fresh = 1'b1;
        repeat (4) @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({gs, go, jr} !== 3'b000 || sc !== 14'd0) begin n_err++; $display("FAIL midreset: got %b%b%b sc %0d want 000 sc 0", gs, go, jr, sc); end
        fresh = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        model_reset();
        press(1'b1, 1'b0);
        n_cmp++; if (gs !== 1'b1 || sc !== 14'd0) begin n_err++; $display("FAIL midreset_start: got st %b sc %0d want st 1 sc 0", gs, sc); end
    endtask

`ifdef GAME_HISCORE_EN
    task automatic test_hiscore();
        repeat (72) frame(2'b00, 1'b0);
        frame(2'b11, 1'b0);
        n_cmp++; if (go !== 1'b1 || hs !== 14'(m_hi)) begin n_err++; $display("FAIL hiscore_first: got over %b hs %0d want over 1 hs %0d", go, hs, m_hi); end
        press(1'b1, 1'b0);
        n_cmp++; if (hs !== 14'(m_hi)) begin n_err++; $display("FAIL hiscore_restart: got %0d want %0d", hs, m_hi); end
        repeat (30) frame(2'b00, 1'b0);
        frame(2'b11, 1'b0);
        n_cmp++; if (sc !== 14'(exp_sc(DIV, 14)) || hs !== 14'(m_hi)) begin
            n_err++; $display("FAIL hiscore_second: got sc %0d hs %0d want sc %0d hs %0d", sc, hs, exp_sc(DIV, 14), m_hi);
        end
        n_cmp++; if (f_hs !== FW'(m_fhi)) begin n_err++; $display("FAIL hiscore_fast: got %0d want %0d", f_hs, m_fhi); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle_frames();
        test_start();
        test_score();
        test_pause();
        test_collision();
        test_jump();
        test_speed();
        test_both();
        test_random();
        test_reset_midframe();
`ifdef GAME_HISCORE_EN
        test_hiscore();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
